// File: rtl/intra_4x4_fdct_pkg.sv
// rtl/intra_4x4_fdct_pkg.sv - shared widths, block types and FSM states for the 4x4 forward core transform
package intra_4x4_fdct_pkg;

  localparam int RES_W  = 9;
  localparam int MID_W  = 12;
  localparam int COEF_W = 16;

  typedef enum logic [1:0] {IDLE, HOR, VER, OUT} fdct_state_t;

  typedef logic [0:3][0:3][RES_W-1:0]  res_blk_t;
  typedef logic [0:3][0:3][MID_W-1:0]  mid_blk_t;
  typedef logic [0:3][0:3][COEF_W-1:0] coef_blk_t;

  function automatic logic [MID_W-1:0] res_to_mid(input logic [RES_W-1:0] r);
    return {{(MID_W-RES_W){r[RES_W-1]}}, r};
  endfunction

endpackage

// File: rtl/intra_4x4_fdct_if.sv
// rtl/intra_4x4_fdct_if.sv - residual-in / coefficient-out block handshake bundle
interface intra_4x4_fdct_if;
  import intra_4x4_fdct_pkg::*;

  logic      res_valid;
  logic      res_ready;
  res_blk_t  res_in;
  logic      coef_valid;
  logic      coef_ready;
  coef_blk_t coef_out;
  logic      busy;

  modport master (
    output res_valid, res_in, coef_ready,
    input  res_ready, coef_valid, coef_out, busy
  );

  modport slave (
    input  res_valid, res_in, coef_ready,
    output res_ready, coef_valid, coef_out, busy
  );

endinterface

// File: rtl/intra_4x4_fdct_fdct4_1d.sv
// rtl/intra_4x4_fdct_fdct4_1d.sv - combinational 4-point H.264 core butterfly
module fdct4_1d #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic signed [IN_W-1:0]  c,
  input  logic signed [IN_W-1:0]  d,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  logic signed [OUT_W-1:0] ea, eb, ec, ed;

  assign ea = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
  assign eb = {{(OUT_W-IN_W){b[IN_W-1]}}, b};
  assign ec = {{(OUT_W-IN_W){c[IN_W-1]}}, c};
  assign ed = {{(OUT_W-IN_W){d[IN_W-1]}}, d};

  // Shared sums/differences keep the adder tree to the classic butterfly shape
  logic signed [OUT_W-1:0] s03, s12, d03, d12;

  assign s03 = ea + ed;
  assign s12 = eb + ec;
  assign d03 = ea - ed;
  assign d12 = eb - ec;

  assign y0 = s03 + s12;
  assign y2 = s03 - s12;
  assign y1 = (d03 <<< 1) + d12;
  assign y3 = d03 - (d12 <<< 1);

endmodule

// File: rtl/intra_4x4_fdct.sv
// rtl/intra_4x4_fdct.sv - row-then-column 4x4 forward integer transform over one shared butterfly
module intra_4x4_fdct
  import intra_4x4_fdct_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  intra_4x4_fdct_if.slave bus
);

  fdct_state_t state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        res_ready_c;
  logic        accept;

  res_blk_t  in_buf;
  mid_blk_t  mid_buf;
  coef_blk_t out_buf;

  logic signed [MID_W-1:0]  bf_in  [4];
  logic signed [COEF_W-1:0] bf_out [4];

  // HOR feeds input row k; VER feeds intermediate column k
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      bf_in[j] = res_to_mid(in_buf[k_q][j]);
      if (state_q == VER) begin
        bf_in[j] = mid_buf[j][k_q];
      end
    end
  end

  fdct4_1d #(
    .IN_W  (MID_W),
    .OUT_W (COEF_W)
  ) u_bfly (
    .a  (bf_in[0]),
    .b  (bf_in[1]),
    .c  (bf_in[2]),
    .d  (bf_in[3]),
    .y0 (bf_out[0]),
    .y1 (bf_out[1]),
    .y2 (bf_out[2]),
    .y3 (bf_out[3])
  );

  // In OUT the slot frees on the same edge the result is taken
  always_comb begin
    res_ready_c = 1'b0;
    case (state_q)
      IDLE:    res_ready_c = 1'b1;
      OUT:     res_ready_c = bus.coef_ready;
      default: res_ready_c = 1'b0;
    endcase
  end

  assign accept = bus.res_valid & res_ready_c;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        k_d = 2'd0;
        if (accept) state_d = HOR;
      end
      HOR: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = VER;
      end
      VER: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = OUT;
      end
      OUT: begin
        k_d = 2'd0;
        if (bus.coef_ready) state_d = bus.res_valid ? HOR : IDLE;
      end
      default: begin
        state_d = IDLE;
        k_d     = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Horizontal results never exceed MID_W bits, so the truncation is lossless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_buf  <= '0;
      mid_buf <= '0;
      out_buf <= '0;
    end else begin
      if (accept) in_buf <= bus.res_in;
      if (state_q == HOR) begin
        for (int j = 0; j < 4; j++) mid_buf[k_q][j] <= bf_out[j][MID_W-1:0];
      end
      if (state_q == VER) begin
        for (int j = 0; j < 4; j++) out_buf[j][k_q] <= bf_out[j];
      end
    end
  end

  assign bus.res_ready  = res_ready_c;
  assign bus.coef_valid = (state_q == OUT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.coef_out   = out_buf;

endmodule
